exit_billing: RTL and testbench

- Exit-side counterpart to the entry path. Reads a spot's occupancy time and computes the parking fee.
- Collects payment through a valid-qualified payment interface.
- Issues a one-cycle exit pulse that drives the top-level exit / spot-release inputs.
- Sits between the driver-facing exit kiosk and the parking controller's exit, spot-select and spot-time signals.

---
 rtl/exit_billing.sv | 183 ++++++++++++++++++
 tb/tb_exit_billing.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exit_billing.sv
// -----------------------------------------------------------------------------
// exit_billing
//   Exit-side billing for the parking controller. On an exit request for an
//   occupied spot it latches that spot's elapsed time, computes a fee
//   (ceil(time / 2^UNIT_SHIFT) billing units, at least one, times RATE,
//   capped at MAX_FEE), collects payment and then either releases the spot
//   with a one-cycle exit pulse or refunds on cancel.
//
// Ports
//   CLK, RST            clock; synchronous active-low reset
//   exit_req, exit_spot exit request and the spot being vacated (IDLE only)
//   F                   occupancy flags, bit i = spot i occupied
//   spot0..3_time       elapsed ticks per spot, sampled at accept
//   pay_valid/amount    payment increment, accepted only while fee_valid
//   cancel              abort during payment; refunds what was paid
//   fee, fee_valid      computed fee; fee_valid = payment window open
//   paid, change        accumulated payment, overpayment or refund amount
//   exit_pulse          one cycle: release spot and gate
//   release_spot        released spot index, valid with exit_pulse
//   busy                transaction in progress
//   error               one cycle: request for an empty spot
//
// Payment handshake: a payment is consumed on every rising CLK edge where
//   pay_valid=1 and fee_valid=1; there is no back-pressure, so pay_valid
//   is a single-cycle strobe per increment. cancel in the same cycle wins
//   and that cycle's pay_amount is dropped.
// -----------------------------------------------------------------------------
module exit_billing #(
  parameter int FEE_W      = 16,
  parameter int RATE       = 5,
  parameter int UNIT_SHIFT = 4,
  parameter int MAX_FEE    = 1000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             exit_req,
  input  logic [1:0]       exit_spot,
  input  logic [3:0]       F,
  input  logic [63:0]      spot0_time,
  input  logic [63:0]      spot1_time,
  input  logic [63:0]      spot2_time,
  input  logic [63:0]      spot3_time,
  input  logic             pay_valid,
  input  logic [FEE_W-1:0] pay_amount,
  input  logic             cancel,
  output logic [FEE_W-1:0] fee,
  output logic             fee_valid,
  output logic [FEE_W-1:0] paid,
  output logic [FEE_W-1:0] change,
  output logic             exit_pulse,
  output logic [1:0]       release_spot,
  output logic             busy,
  output logic             error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CALC     = 3'd1,
    S_WAIT_PAY = 3'd2,
    S_RELEASE  = 3'd3,
    S_REFUND   = 3'd4
  } state_t;

  // Rounding term for the ceiling division, held in 65 bits so that an
  // all-ones time does not wrap when the round-up is added.
  localparam logic [64:0]      LP_ROUND   = (65'd1 << UNIT_SHIFT) - 65'd1;
  localparam logic [96:0]      LP_RATE_W  = 97'(RATE);
  localparam logic [96:0]      LP_MAX_W   = 97'(MAX_FEE);
  localparam logic [FEE_W-1:0] LP_MAX_FEE = FEE_W'(MAX_FEE);

  state_t           r_state;
  logic [1:0]       r_spot;
  logic [63:0]      r_time;
  logic [FEE_W-1:0] r_fee;
  logic             r_fee_valid;
  logic [FEE_W-1:0] r_paid;
  logic [FEE_W-1:0] r_change;
  logic             r_exit_pulse;
  logic [1:0]       r_release_spot;
  logic             r_error;

  logic [63:0]      w_sel_time;
  logic [64:0]      w_sum;
  logic [64:0]      w_units;
  logic [64:0]      w_units_min;
  logic [96:0]      w_raw;
  logic [FEE_W-1:0] w_fee_calc;
  logic [FEE_W:0]   w_pay_sum;
  logic [FEE_W-1:0] w_paid_sat;
  logic [FEE_W-1:0] w_paid_next;

  always_comb begin
    w_sel_time = spot0_time;
    case (exit_spot)
      2'd0:    w_sel_time = spot0_time;
      2'd1:    w_sel_time = spot1_time;
      2'd2:    w_sel_time = spot2_time;
      default: w_sel_time = spot3_time;
    endcase
  end

  // Fee from the latched time. The product is kept wide enough that it can
  // never overflow, so one compare against MAX_FEE covers all saturation.
  assign w_sum       = {1'b0, r_time} + LP_ROUND;
  assign w_units     = w_sum >> UNIT_SHIFT;
  assign w_units_min = (w_units == 65'd0) ? 65'd1 : w_units;
  assign w_raw       = {32'd0, w_units_min} * LP_RATE_W;
  assign w_fee_calc  = (w_raw > LP_MAX_W) ? LP_MAX_FEE : w_raw[FEE_W-1:0];

  // Running payment total, saturating at all-ones.
  assign w_pay_sum   = {1'b0, r_paid} + {1'b0, pay_amount};
  assign w_paid_sat  = w_pay_sum[FEE_W] ? {FEE_W{1'b1}} : w_pay_sum[FEE_W-1:0];
  assign w_paid_next = pay_valid ? w_paid_sat : r_paid;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state        <= S_IDLE;
      r_spot         <= 2'd0;
      r_time         <= 64'd0;
      r_fee          <= '0;
      r_fee_valid    <= 1'b0;
      r_paid         <= '0;
      r_change       <= '0;
      r_exit_pulse   <= 1'b0;
      r_release_spot <= 2'd0;
      r_error        <= 1'b0;
    end else begin
      r_error      <= 1'b0;
      r_exit_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (exit_req) begin
            if (F[exit_spot]) begin
              r_spot   <= exit_spot;
              r_time   <= w_sel_time;
              r_paid   <= '0;
              r_change <= '0;
              r_state  <= S_CALC;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_CALC: begin
          r_fee       <= w_fee_calc;
          r_fee_valid <= 1'b1;
          r_state     <= S_WAIT_PAY;
        end
        S_WAIT_PAY: begin
          if (cancel) begin
            r_change    <= r_paid;
            r_fee_valid <= 1'b0;
            r_state     <= S_REFUND;
          end else begin
            r_paid <= w_paid_next;
            // Compare against the updated total; a zero fee releases here
            // even without any payment.
            if (w_paid_next >= r_fee) begin
              r_change       <= w_paid_next - r_fee;
              r_fee_valid    <= 1'b0;
              r_exit_pulse   <= 1'b1;
              r_release_spot <= r_spot;
              r_state        <= S_RELEASE;
            end
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        S_REFUND:  r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign fee          = r_fee;
  assign fee_valid    = r_fee_valid;
  assign paid         = r_paid;
  assign change       = r_change;
  assign exit_pulse   = r_exit_pulse;
  assign release_spot = r_release_spot;
  assign busy         = (r_state != S_IDLE);
  assign error        = r_error;

endmodule

// File: tb/tb_exit_billing.sv
// -----------------------------------------------------------------------------
// tb_exit_billing
//   Self-checking bench for exit_billing. Driver tasks issue transactions and
//   push expected events (fee, release, refund, error) into queues; a monitor
//   on the falling clock edge pops and compares whenever the DUT shows one.
// -----------------------------------------------------------------------------
module tb_exit_billing;

  localparam int FEE_W      = 16;
  localparam int RATE       = 5;
  localparam int UNIT_SHIFT = 4;
  localparam int MAX_FEE    = 1000;
  localparam int PAID_MAX   = 65535;
  localparam logic [63:0] BILL_UNIT = 64'd1 << UNIT_SHIFT;

  // ---------------- clock / reset / DUT ----------------
  logic             CLK = 1'b0;
  logic             RST;
  logic             exit_req;
  logic [1:0]       exit_spot;
  logic [3:0]       F;
  logic [63:0]      st [4];
  logic             pay_valid;
  logic [FEE_W-1:0] pay_amount;
  logic             cancel;
  logic [FEE_W-1:0] fee;
  logic             fee_valid;
  logic [FEE_W-1:0] paid;
  logic [FEE_W-1:0] change;
  logic             exit_pulse;
  logic [1:0]       release_spot;
  logic             busy;
  logic             error;

  always #5 CLK = ~CLK;

  exit_billing #(
    .FEE_W(FEE_W), .RATE(RATE), .UNIT_SHIFT(UNIT_SHIFT), .MAX_FEE(MAX_FEE)
  ) dut (
    .CLK(CLK), .RST(RST), .exit_req(exit_req), .exit_spot(exit_spot), .F(F),
    .spot0_time(st[0]), .spot1_time(st[1]), .spot2_time(st[2]), .spot3_time(st[3]),
    .pay_valid(pay_valid), .pay_amount(pay_amount), .cancel(cancel),
    .fee(fee), .fee_valid(fee_valid), .paid(paid), .change(change),
    .exit_pulse(exit_pulse), .release_spot(release_spot), .busy(busy), .error(error)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [FEE_W-1:0] exp_fee_q [$];
  logic [33:0]      exp_rel_q [$];   // {spot, paid, change}
  logic [FEE_W-1:0] exp_ref_q [$];
  logic [0:0]       exp_err_q [$];
  int pay_list [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=no_event required=event", name);
  endtask

  // Reference fee: ceiling of time over the billing unit, minimum one unit,
  // priced at RATE per unit and capped at MAX_FEE.
  function automatic logic [FEE_W-1:0] fee_model(input logic [63:0] t);
    logic [63:0] units;
    units = t / BILL_UNIT;
    if ((t % BILL_UNIT) != 64'd0) units = units + 64'd1;
    if (units == 64'd0) units = 64'd1;
    if (units > 64'(MAX_FEE)) return FEE_W'(MAX_FEE);
    if (units * 64'(RATE) > 64'(MAX_FEE)) return FEE_W'(MAX_FEE);
    return FEE_W'(units * 64'(RATE));
  endfunction

  // ---------------- monitor ----------------
  logic             prev_fv = 1'b0;
  logic [FEE_W-1:0] cur_fee = '0;
  logic [33:0]      rel_e;
  logic [FEE_W-1:0] ref_e;

  always @(negedge CLK) begin
    if (fee_valid === 1'b1 && prev_fv !== 1'b1) begin
      if (exp_fee_q.size() == 0) fail_now("fee_unexpected");
      else begin
        cur_fee = exp_fee_q.pop_front();
        check("fee", 64'(fee), 64'(cur_fee));
      end
    end else if (fee_valid === 1'b1) begin
      check("fee_hold", 64'(fee), 64'(cur_fee));
    end
    if (exit_pulse === 1'b1) begin
      if (exp_rel_q.size() == 0) fail_now("exit_pulse_unexpected");
      else begin
        rel_e = exp_rel_q.pop_front();
        check("release_spot", 64'(release_spot), 64'(rel_e[33:32]));
        check("release_paid", 64'(paid), 64'(rel_e[31:16]));
        check("release_change", 64'(change), 64'(rel_e[15:0]));
      end
    end
    if (prev_fv === 1'b1 && fee_valid === 1'b0 && busy === 1'b1 && exit_pulse === 1'b0) begin
      if (exp_ref_q.size() == 0) fail_now("refund_unexpected");
      else begin
        ref_e = exp_ref_q.pop_front();
        check("refund_change", 64'(change), 64'(ref_e));
      end
    end
    if (error === 1'b1) begin
      if (exp_err_q.size() == 0) fail_now("error_unexpected");
      else begin
        void'(exp_err_q.pop_front());
        check("error_busy", 64'(busy), 64'd0);
      end
    end
    prev_fv = fee_valid;
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    exit_req = 1'b0; exit_spot = 2'd0; F = 4'd0;
    pay_valid = 1'b0; pay_amount = '0; cancel = 1'b0;
    for (int k = 0; k < 4; k++) st[k] = 64'd0;
  endtask

  // Issue a request and wait for the payment window. ok=0 for an empty spot
  // or when fee_valid never arrives.
  task automatic start_txn(input logic [1:0] spot, input logic [3:0] flags,
                           input logic [63:0] t, output logic [FEE_W-1:0] f, output bit ok);
    int lat;
    ok = 1'b0;
    f  = '0;
    @(negedge CLK);
    for (int k = 0; k < 4; k++) st[k] = {$urandom, $urandom};
    st[spot] = t; F = flags; exit_spot = spot; exit_req = 1'b1;
    if (!flags[spot]) begin
      exp_err_q.push_back(1'b1);
      @(negedge CLK);
      exit_req = 1'b0;
      check("busy_after_error", 64'(busy), 64'd0);
      repeat (3) begin
        @(negedge CLK);
        check("no_fee_valid_after_error", 64'(fee_valid), 64'd0);
      end
      return;
    end
    f = fee_model(t);
    exp_fee_q.push_back(f);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
      exit_req = 1'b0;
      // Time and flag changes after accept must not matter.
      st[spot] = {$urandom, $urandom};
      F = 4'($urandom_range(0, 15));
    end while (fee_valid !== 1'b1 && lat < 8);
    if (fee_valid !== 1'b1) begin
      fail_now("fee_valid_wait");
      return;
    end
    check("fee_latency", 64'(lat), 64'd2);
    ok = 1'b1;
  endtask

  // Full transaction: payments from pay_list; cancel at cancel_idx (or when
  // the list runs out before the fee is covered).
  task automatic run_txn(input logic [1:0] spot, input logic [3:0] flags, input logic [63:0] t,
                         input int cancel_idx, input bit cancel_pay, input logic [FEE_W-1:0] cancel_amt,
                         input bit poke);
    logic [FEE_W-1:0] f;
    bit ok;
    bit done;
    int p;
    int exp_change;
    int lat;
    start_txn(spot, flags, t, f, ok);
    if (!ok) return;
    p = 0; done = 1'b0; exp_change = 0;
    for (int i = 0; i < pay_list.size() && !done; i++) begin
      if (i == cancel_idx) break;
      if (poke && $urandom_range(0, 1) == 1) begin
        exit_req = 1'b1; exit_spot = spot + 2'd1; F = 4'hF;
        @(negedge CLK);
        exit_req = 1'b0;
        check("busy_during_poke", 64'(busy), 64'd1);
      end
      pay_valid = 1'b1;
      pay_amount = FEE_W'(pay_list[i]);
      p = p + pay_list[i];
      if (p > PAID_MAX) p = PAID_MAX;
      if (p >= int'(f)) begin
        exp_change = p - int'(f);
        exp_rel_q.push_back({spot, FEE_W'(p), FEE_W'(exp_change)});
        done = 1'b1;
      end
      @(negedge CLK);
      pay_valid = 1'b0;
      check("paid", 64'(paid), 64'(p));
    end
    if (!done) begin
      cancel = 1'b1; pay_valid = cancel_pay; pay_amount = cancel_amt;
      exp_change = p;
      exp_ref_q.push_back(FEE_W'(p));
      @(negedge CLK);
      cancel = 1'b0; pay_valid = 1'b0;
      check("paid_after_cancel", 64'(paid), 64'(p));
    end
    lat = 0;
    while (busy === 1'b1 && lat < 5) begin
      @(negedge CLK);
      lat++;
    end
    if (busy !== 1'b0) fail_now("busy_clear_wait");
    // Payment and cancel are ignored in IDLE; results hold.
    pay_valid = 1'b1; pay_amount = 16'd50; cancel = 1'b1;
    @(negedge CLK);
    pay_valid = 1'b0; cancel = 1'b0;
    check("paid_hold_idle", 64'(paid), 64'(p));
    check("change_hold_idle", 64'(change), 64'(exp_change));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [FEE_W-1:0] f;
    bit ok;
    logic [63:0] t;
    int n;
    int lat;

    idle_inputs();
    // Reset with a pending request for an empty spot: nothing may fire.
    RST = 1'b0; exit_req = 1'b1; exit_spot = 2'd1; F = 4'd0;
    repeat (2) @(negedge CLK);
    check("rst_fee", 64'(fee), 64'd0);
    check("rst_fee_valid", 64'(fee_valid), 64'd0);
    check("rst_paid", 64'(paid), 64'd0);
    check("rst_change", 64'(change), 64'd0);
    check("rst_exit_pulse", 64'(exit_pulse), 64'd0);
    check("rst_release_spot", 64'(release_spot), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    RST = 1'b1; exit_req = 1'b0;

    // Spot 2, 33 ticks: fee 15; pay 10+10 -> change 5.
    pay_list = '{10, 10};
    run_txn(2'd2, 4'b0100, 64'd33, -1, 1'b0, '0, 1'b0);

    // Empty spot request -> error pulse only.
    run_txn(2'd1, 4'b0100, 64'd100, -1, 1'b0, '0, 1'b0);

    // Zero time bills one unit; all-ones time saturates.
    pay_list = '{5};
    run_txn(2'd0, 4'b0001, 64'd0, -1, 1'b0, '0, 1'b0);
    pay_list = '{600, 600};
    run_txn(2'd3, 4'b1000, 64'hFFFF_FFFF_FFFF_FFFF, -1, 1'b0, '0, 1'b0);

    // Cancel wins over a same-cycle payment: refund 7.
    pay_list = '{7, 8};
    run_txn(2'd2, 4'b0100, 64'd33, 1, 1'b1, 16'd8, 1'b0);

    // Ignored request while busy, then reset mid-transaction.
    start_txn(2'd1, 4'b0110, 64'd40, f, ok);
    if (ok) begin
      pay_valid = 1'b1; pay_amount = 16'd3;
      @(negedge CLK);
      pay_valid = 1'b0;
      check("mid_paid", 64'(paid), 64'd3);
      exit_req = 1'b1; exit_spot = 2'd2; F = 4'b0110;
      @(negedge CLK);
      exit_req = 1'b0;
      check("mid_fee_unchanged", 64'(fee), 64'(f));
      check("mid_busy", 64'(busy), 64'd1);
      RST = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      check("mid_rst_fee_valid", 64'(fee_valid), 64'd0);
      check("mid_rst_paid", 64'(paid), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_exit_pulse", 64'(exit_pulse), 64'd0);
      check("mid_rst_change", 64'(change), 64'd0);
      @(negedge CLK);
      check("mid_rst_no_pulse_after", 64'(exit_pulse), 64'd0);
    end

    // Randomized transactions.
    for (int r = 0; r < 40; r++) begin
      case ($urandom_range(0, 3))
        0:       t = 64'($urandom_range(0, 64));
        1:       t = 64'($urandom_range(0, 5000));
        2:       t = 64'($urandom_range(3150, 3250));
        default: t = {$urandom, $urandom};
      endcase
      pay_list = {};
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 9) == 0) pay_list.push_back($urandom_range(60000, 65535));
        else pay_list.push_back($urandom_range(1, 300));
      end
      run_txn(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), t,
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : -1,
              1'($urandom_range(0, 1)), FEE_W'($urandom_range(1, 500)), 1'b1);
    end

    lat = 0;
    while (busy === 1'b1 && lat < 10) begin
      @(negedge CLK);
      lat++;
    end
    repeat (3) @(negedge CLK);
    check("fee_queue_empty", 64'(exp_fee_q.size()), 64'd0);
    check("release_queue_empty", 64'(exp_rel_q.size()), 64'd0);
    check("refund_queue_empty", 64'(exp_ref_q.size()), 64'd0);
    check("error_queue_empty", 64'(exp_err_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
